clkgen_ctrl: RTL and testbench

Programmable clock-enable generator and controller. It derives a divided, optionally inverted square wave (`clk_out`) from the system clock. A valid/ready configuration port changes the divide ratio and polarity without glitches, and new settings take effect only at a period boundary. The block sits between the test or top-level control logic and the clock-inverter/pass-through datapath it drives, and sequences start, stop and reconfiguration of that datapath.

---
 rtl/clkgen_ctrl.sv | 110 +++++++++++
 tb/tb_clkgen_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/clkgen_ctrl.sv
// Programmable divided square-wave generator with glitch-free reconfiguration.
// Divide ratio and polarity changes are deferred to the next period boundary while running.
module clkgen_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_inv,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_reg, div_n;
  logic [CNT_W-1:0] pend_div, pend_div_n;
  logic             phase, phase_n;
  logic             inv_reg, inv_n;
  logic             pend_inv, pend_inv_n;
  logic             accept;
  logic             at_end;
  logic             boundary;

  assign cfg_ready = (state != SWITCH);
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign at_end    = (cnt == div_reg);
  assign boundary  = (state != IDLE) && at_end && phase;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    phase_n    = phase;
    div_n      = div_reg;
    inv_n      = inv_reg;
    pend_div_n = pend_div;
    pend_inv_n = pend_inv;

    case (state)
      IDLE: begin
        cnt_n   = '0;
        phase_n = 1'b0;
        if (accept) begin
          div_n = cfg_div;
          inv_n = cfg_inv;
        end
        if (en) state_n = RUN;
      end
      RUN, SWITCH: begin
        if (at_end) begin
          cnt_n   = '0;
          phase_n = ~phase;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        if (state == RUN) begin
          // An offer taken on a boundary edge still waits for the following boundary.
          if (accept) begin
            pend_div_n = cfg_div;
            pend_inv_n = cfg_inv;
            state_n    = SWITCH;
          end else if (boundary && !en) begin
            state_n = IDLE;
          end
        end else if (boundary) begin
          div_n   = pend_div;
          inv_n   = pend_inv;
          state_n = en ? RUN : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= 1'b0;
      div_reg  <= '0;
      inv_reg  <= 1'b0;
      pend_div <= '0;
      pend_inv <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      div_reg  <= div_n;
      inv_reg  <= inv_n;
      pend_div <= pend_div_n;
      pend_inv <= pend_inv_n;
      clk_out  <= phase_n ^ inv_n;
      tick     <= boundary;
    end
  end

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Directed self-checking bench for clkgen_ctrl: default-width instance plus a CNT_W=4 instance.
module tb_clkgen_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       cfg_inv = 1'b0;
  logic       cfg_ready, clk_out, tick, busy;

  logic       en2 = 1'b0;
  logic       cfg_valid2 = 1'b0;
  logic [3:0] cfg_div2 = '0;
  logic       cfg_inv2 = 1'b0;
  logic       cfg_ready2, clk_out2, tick2, busy2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [16:0] exp_clk17, exp_tick17, exp_rdy17;
  logic [12:0] exp_clk13, exp_tick13, exp_rdy13;
  logic [9:0]  exp_clk10, exp_busy10, exp_tick10;

  always #5 clk = ~clk;

  clkgen_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_inv(cfg_inv), .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  clkgen_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en2), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .cfg_div(cfg_div2), .cfg_inv(cfg_inv2), .clk_out(clk_out2), .tick(tick2), .busy(busy2)
  );

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; en2 = 1'b0; cfg_valid2 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_clk_out", clk_out, 1'b0);
    check_eq("rst_tick", tick, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", cfg_ready, 1'b1);

    // div=0 with config and en on the same edge
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_inv = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      cfg_valid = 1'b0;
      check_eq("div0_clk", clk_out, (k % 2) == 1);
      check_eq("div0_tick", tick, (k >= 2) && (k % 2 == 0));
      check_eq("div0_busy", busy, 1'b1);
    end

    // polarity change in IDLE is immediate
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_inv = 1'b1;
    step();
    cfg_valid = 1'b0;
    check_eq("idle_inv_clk", clk_out, 1'b1);
    check_eq("idle_inv_busy", busy, 1'b0);
    step();
    check_eq("idle_inv_hold", clk_out, 1'b1);
    check_eq("idle_inv_tick", tick, 1'b0);

    // reconfig mid-run: div=3 -> div=1, inv=1
    do_reset();
    exp_clk17  = 17'b1_0011_0011_1111_0000;
    exp_tick17 = 17'b1_0001_0001_0000_0000;
    exp_rdy17  = 17'b1_1111_1111_0000_0011;
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_inv = 1'b0; en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check_eq("recfg_clk", clk_out, exp_clk17[k]);
      check_eq("recfg_tick", tick, exp_tick17[k]);
      check_eq("recfg_ready", cfg_ready, exp_rdy17[k]);
      cfg_valid = 1'b0;
      if (k == 1) begin
        cfg_valid = 1'b1; cfg_div = 8'd1; cfg_inv = 1'b1;
      end
    end

    // acceptance exactly on a boundary edge: div=1 -> div=0
    do_reset();
    exp_clk13  = 13'b0_1010_1100_1100;
    exp_tick13 = 13'b1_0101_0001_0000;
    exp_rdy13  = 13'b1_1111_0000_1111;
    cfg_valid = 1'b1; cfg_div = 8'd1; cfg_inv = 1'b0; en = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      check_eq("bnd_clk", clk_out, exp_clk13[k]);
      check_eq("bnd_tick", tick, exp_tick13[k]);
      check_eq("bnd_ready", cfg_ready, exp_rdy13[k]);
      cfg_valid = 1'b0;
      if (k == 3) begin
        cfg_valid = 1'b1; cfg_div = 8'd0;
      end
    end

    // stop request: div=2, en dropped one cycle after clk_out rises
    do_reset();
    exp_clk10  = 10'b00_0011_1000;
    exp_busy10 = 10'b00_0011_1111;
    exp_tick10 = 10'b00_0100_0000;
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_inv = 1'b0; en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      cfg_valid = 1'b0;
      check_eq("stop_clk", clk_out, exp_clk10[k]);
      check_eq("stop_busy", busy, exp_busy10[k]);
      check_eq("stop_tick", tick, exp_tick10[k]);
      if (k == 4) en = 1'b0;
    end

    // reset while SWITCH: pending config is discarded
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd5; cfg_inv = 1'b0; en = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    check_eq("sw_ready", cfg_ready, 1'b0);
    check_eq("sw_busy", busy, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("sw_rst_clk", clk_out, 1'b0);
    check_eq("sw_rst_tick", tick, 1'b0);
    check_eq("sw_rst_busy", busy, 1'b0);
    check_eq("sw_rst_ready", cfg_ready, 1'b1);
    for (int j = 0; j < 5; j++) begin
      step();
      check_eq("sw_restart_clk", clk_out, (j % 2) == 1);
      check_eq("sw_restart_tick", tick, (j >= 2) && (j % 2 == 0));
    end
    en = 1'b0;

    // max divide on the 4-bit instance: period 32
    do_reset();
    cfg_valid2 = 1'b1; cfg_div2 = 4'd15; cfg_inv2 = 1'b0; en2 = 1'b1;
    step();
    cfg_valid2 = 1'b0;
    check_eq("max_clk_start", clk_out2, 1'b0);
    check_eq("max_busy", busy2, 1'b1);
    for (int k = 1; k <= 96; k++) begin
      step();
      check_eq("max_clk", clk_out2, ((k / 16) % 2) == 1);
      check_eq("max_tick", tick2, (k % 32) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
